stage_fetch: RTL and testbench

STAGE_FETCH -- requirements
Module: stage_fetch

---
 rtl/stage_fetch_pkg.sv | 30 +++
 rtl/stage_fetch_fetch_buffer.sv | 72 +++++++
 rtl/stage_fetch.sv | 144 ++++++++++++++
 tb/tb_stage_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package stage_fetch_pkg;

    // Fetch control states: normal fetching, or draining stale responses.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

    // One decode-buffer entry: fetch address and its instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;
    localparam logic [1:0]  c_buf_depth        = 2'd2;

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_fetch_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Two-entry in-order {pc, insn} FIFO with flush. Entry 0 is
//               always the head so the outputs come straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import stage_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_insn,
    input  logic        pop,
    output logic        head_valid,
    output logic [31:0] head_pc,
    output logic [31:0] head_insn,
    output logic [1:0]  count
);

    fetch_entry_t r_ent0;
    fetch_entry_t r_ent1;
    logic [1:0]   r_count;
    fetch_entry_t w_new;
    logic         w_pop;

    assign w_new      = '{pc: push_pc, insn: push_insn};
    assign w_pop      = pop & (r_count != 2'd0);
    assign head_valid = (r_count != 2'd0);
    assign head_pc    = r_ent0.pc;
    assign head_insn  = r_ent0.insn;
    assign count      = r_count;

    // Storage update: flush empties the FIFO and overrides push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    if (r_count != c_buf_depth) begin
                        if (r_count == 2'd0) r_ent0 <= w_new;
                        else                 r_ent1 <= w_new;
                        r_count <= r_count + 2'd1;
                    end
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ent0 <= w_new;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_fetch.sv
`default_nettype none
// ============================================================================
// Module      : stage_fetch
// Description : Instruction fetch stage. Issues word reads, tracks up to two
//               outstanding requests, buffers responses for decode and
//               squashes stale responses after a control-flow redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc_default
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    input  logic        de_stall,
    output logic        de_valid,
    output logic [31:0] de_insn,
    output logic [31:0] de_pc
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [1:0]   r_outstanding;
    logic [1:0]   r_drop;
    logic [31:0]  r_iq0;
    logic [31:0]  r_iq1;

    logic [1:0]   w_count;
    logic         w_pop;
    logic         w_push;
    logic         w_accept;
    logic         w_rsp;
    logic [2:0]   w_occupancy;
    logic [1:0]   w_outstanding_nxt;
    logic [1:0]   w_drop_nxt;
    logic [31:0]  w_iq0_nxt;
    logic [31:0]  w_iq1_nxt;
    logic [31:0]  w_target;
    logic         w_unused;

    // Low target bits are architecturally ignored.
    assign w_target = {br_target[31:2], 2'b00};
    assign w_unused = ^br_target[1:0];

    // A request is only issued if its response is guaranteed a buffer slot.
    assign w_pop       = de_valid & ~de_stall;
    assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_count} - {2'b00, w_pop};
    assign imem_req    = reset_n & (r_state == ST_RUN) & ~br_redirect & (w_occupancy < 3'd2);
    assign imem_addr   = r_pc;
    assign w_accept    = imem_req & imem_ready;
    assign w_rsp       = imem_rvalid & (r_outstanding != 2'd0);
    assign w_push      = w_rsp & (r_state == ST_RUN) & ~br_redirect;

    // Issued-address queue: responses retire the head, accepts append.
    always_comb begin
        w_iq0_nxt         = r_iq0;
        w_iq1_nxt         = r_iq1;
        w_outstanding_nxt = r_outstanding;
        if (w_rsp) begin
            w_iq0_nxt         = r_iq1;
            w_outstanding_nxt = r_outstanding - 2'd1;
        end
        if (w_accept) begin
            if (w_outstanding_nxt == 2'd0) w_iq0_nxt = r_pc;
            else                           w_iq1_nxt = r_pc;
            w_outstanding_nxt = w_outstanding_nxt + 2'd1;
        end
    end

    // Next state and drop count; a redirect turns in-flight reads into drops.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        case (r_state)
            ST_RUN: begin
                if (br_redirect) begin
                    w_drop_nxt  = r_outstanding - {1'b0, w_rsp};
                    w_state_nxt = (w_drop_nxt != 2'd0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_rsp) w_drop_nxt = r_drop - 2'd1;
                w_state_nxt = (w_drop_nxt != 2'd0) ? ST_FLUSH : ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_drop_nxt  = 2'd0;
            end
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_outstanding <= 2'd0;
            r_drop        <= 2'd0;
            r_iq0         <= '0;
            r_iq1         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_drop_nxt;
            r_iq0         <= w_iq0_nxt;
            r_iq1         <= w_iq1_nxt;
            if (br_redirect)   r_pc <= w_target;
            else if (w_accept) r_pc <= pc_plus4(r_pc);
        end
    end

`ifndef SYNTHESIS
    // Flag a response that no request accounts for; it is ignored.
    always_ff @(posedge clk) begin
        if (reset_n && imem_rvalid && (r_outstanding == 2'd0))
            $display("stage_fetch: unexpected imem_rvalid with nothing outstanding at %0t", $time);
    end
`endif

    fetch_buffer u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (br_redirect),
        .push       (w_push),
        .push_pc    (r_iq0),
        .push_insn  (imem_rdata),
        .pop        (w_pop),
        .head_valid (de_valid),
        .head_pc    (de_pc),
        .head_insn  (de_insn),
        .count      (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_stage_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stage_fetch
// Description : Self-checking bench for stage_fetch: in-order memory
//               responder plus a program-order stream model of decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        br_redirect = 1'b0;
    logic [31:0] br_target = '0;
    logic        de_stall = 1'b0;
    logic        de_valid;
    logic [31:0] de_insn;
    logic [31:0] de_pc;

    always #5 clk = ~clk;

    stage_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .br_redirect (br_redirect),
        .br_target   (br_target),
        .de_stall    (de_stall),
        .de_valid    (de_valid),
        .de_insn     (de_insn),
        .de_pc       (de_pc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Knobs for the per-cycle driver
    int          lat = 1;
    int          ready_pct = 100;
    int          stall_pct = 0;
    int          redir_pm = 0;
    logic        rst_active = 1'b1;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = '0;
    logic        force_stall = 1'b0;

    // Memory responder state
    logic [31:0] rq_addr[$];
    int          rq_due[$];
    int          last_due = 0;
    int          cyc = 0;

    // Decode-side stream model
    logic [31:0] exp_pc = RESET_PC;
    logic        chk_flush = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    int          pops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 + $urandom_range(15);
        else                        t = $urandom;
        return t;
    endfunction

    // One clock cycle: drive after the edge, observe and model at negedge.
    task automatic cycle();
        int due;
        @(posedge clk);
        cyc++;
        #1;
        reset_n     = ~rst_active;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!rst_active && rq_addr.size() > 0 && rq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = insn_of(rq_addr[0]);
        end
        imem_ready  = ($urandom_range(99) < ready_pct);
        de_stall    = force_stall | ($urandom_range(99) < stall_pct);
        br_redirect = force_redir | (!rst_active && ($urandom_range(999) < redir_pm));
        br_target   = force_redir ? force_target : rand_target();
        @(negedge clk);
        if (reset_n) begin
            if (chk_flush) check("flush_clears_valid", de_valid, 32'd0);
            if (prev_wait && !br_redirect) begin
                check("req_held", imem_req, 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (imem_req) check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (br_redirect) begin
                exp_pc = {br_target[31:2], 2'b00};
            end else if (de_valid && !de_stall) begin
                check("de_pc", de_pc, exp_pc);
                check("de_insn", de_insn, insn_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            chk_flush = br_redirect;
            prev_wait = imem_req & ~imem_ready;
            prev_addr = imem_addr;
            if (imem_rvalid) begin
                void'(rq_addr.pop_front());
                void'(rq_due.pop_front());
            end
            if (imem_req && imem_ready) begin
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                rq_addr.push_back(imem_addr);
                rq_due.push_back(due);
                last_due = due;
                check("outstanding_bound", (rq_addr.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
            end
        end else begin
            rq_addr.delete();
            rq_due.delete();
            last_due  = 0;
            exp_pc    = RESET_PC;
            chk_flush = 1'b0;
            prev_wait = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        rst_active = 1'b1;
        repeat (n) cycle();
        check("rst_de_valid", de_valid, 32'd0);
        check("rst_de_pc", de_pc, 32'd0);
        check("rst_de_insn", de_insn, 32'd0);
        check("rst_imem_req", imem_req, 32'd0);
        rst_active = 1'b0;
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] pc, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            if (de_valid && de_pc == pc) seen = 1'b1;
        end
        check(tag, seen, 32'd1);
    endtask

    task automatic redirect_now(input logic [31:0] t);
        force_redir  = 1'b1;
        force_target = t;
        cycle();
        force_redir  = 1'b0;
    endtask

    initial begin
        // Reset values and first fetch, steady one-per-cycle stream
        do_reset(3);
        cycle();
        check("first_req", imem_req, 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        cycle();
        check("cyc2_no_valid", de_valid, 32'd0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("steady_valid", de_valid, 32'd1);
            check("steady_pc", de_pc, RESET_PC + 32'(4 * k));
        end

        // Decode stall at pc 8: head held, no requests, then 8,12,16 resume
        force_stall = 1'b1;
        repeat (5) begin
            cycle();
            check("stall_pc", de_pc, 32'd8);
            check("stall_insn", de_insn, insn_of(32'd8));
            check("stall_req", imem_req, 32'd0);
        end
        force_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("resume_valid", de_valid, 32'd1);
            check("resume_pc", de_pc, 32'd8 + 32'(4 * k));
        end

        // Reset with a full buffer, then refetch from RESET_PC
        force_stall = 1'b1;
        repeat (3) cycle();
        force_stall = 1'b0;
        do_reset(2);
        cycle();
        check("refetch_addr", imem_addr, RESET_PC);
        wait_pc("refetch_stream", RESET_PC + 32'd8, 10);

        // Redirect with empty pipeline, unaligned target
        do_reset(2);
        redirect_now(32'h0000_0203);
        check("redir_blocks_req", imem_req, 32'd0);
        cycle();
        check("redir_req", imem_req, 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0200);
        wait_pc("redir_de_pc", 32'h0000_0200, 6);

        // 3-cycle memory, two outstanding, redirect drains both stale reads
        do_reset(2);
        lat = 3;
        cycle();
        cycle();
        redirect_now(32'h0000_0100);
        cycle();
        check("flush_req_a", imem_req, 32'd0);
        cycle();
        check("flush_req_b", imem_req, 32'd0);
        cycle();
        check("post_flush_req", imem_req, 32'd1);
        check("post_flush_addr", imem_addr, 32'h0000_0100);
        wait_pc("post_flush_pc", 32'h0000_0100, 10);

        // Redirect coincident with response and decode pop
        do_reset(2);
        lat = 1;
        repeat (5) cycle();
        check("coinc_valid", de_valid, 32'd1);
        redirect_now(32'h0000_0300);
        cycle();
        check("coinc_flush", de_valid, 32'd0);
        wait_pc("coinc_pc", 32'h0000_0300, 6);

        // Address wrap at the top of the space
        redirect_now(32'hFFFF_FFF8);
        wait_pc("wrap_pc", 32'h0000_0004, 12);

        // Randomized traffic against the stream model
        for (int seg = 0; seg < 10; seg++) begin
            lat       = $urandom_range(1, 3);
            ready_pct = $urandom_range(30, 100);
            stall_pct = $urandom_range(0, 60);
            redir_pm  = $urandom_range(0, 40);
            if (seg == 5) do_reset(2);
            repeat (400) cycle();
        end
        check("progress", (pops > 200) ? 32'd1 : 32'd0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
